mac_datapath: RTL

- Datapath stage directly downstream of the 3-bit sequencing controller.
- Consumes Asel, Bsel, ans_sel[1:0] and resultRes each cycle; latches operands, runs a multiply-accumulate/subtract sequence and presents the final value on a valid/ready output register.
- Also provides busy and a sticky overrun flag for the surrounding system.

---
 rtl/mac_datapath_if.sv | 30 +++
 rtl/mac_datapath.sv | 103 ++++++++++
 2 files changed

// File: rtl/mac_datapath_if.sv
// Controller/datapath bus for mac_datapath.
//   master: controller side (drives select/op/start, operand streams and out_ready)
//   slave : datapath side  (drives result, result_valid, busy, overrun)
interface mac_datapath_if #(
    parameter int unsigned W = 8
) ();
    localparam int unsigned RW = 2 * W + 2;

    logic          Asel;
    logic          Bsel;
    logic [1:0]    ans_sel;
    logic          resultRes;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          overrun;

    modport master (
        output Asel, Bsel, ans_sel, resultRes, x_in, y_in, out_ready,
        input  result, result_valid, busy, overrun
    );

    modport slave (
        input  Asel, Bsel, ans_sel, resultRes, x_in, y_in, out_ready,
        output result, result_valid, busy, overrun
    );
endinterface

// File: rtl/mac_datapath.sv
// Multiply-accumulate/subtract datapath downstream of the sequencing controller.
// Latches operands on resultRes, accumulates products selected by Asel/Bsel
// under ans_sel, and publishes the final (R - P) on a valid/ready output.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mac_datapath_if.slave: control/operand inputs, out_ready,
//          result/result_valid/busy/overrun outputs (all registered)
module mac_datapath #(
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst,
    mac_datapath_if.slave      bus
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned RW = 2 * W + 2;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [RW-1:0] acc;

    logic [W-1:0]  op_a_c;
    logic [W-1:0]  op_b_c;
    logic [PW-1:0] prod_c;
    logic [RW-1:0] p_ext_c;
    logic [RW-1:0] acc_sub_c;
    logic [RW-1:0] acc_nxt_c;
    logic          complete_c;
    logic          xfer_c;

    // Operand select and unsigned product, zero-extended to accumulator width
    always_comb begin
        op_a_c    = bus.Asel ? a_reg : bus.x_in;
        op_b_c    = bus.Bsel ? b_reg : bus.y_in;
        prod_c    = PW'(op_a_c) * PW'(op_b_c);
        p_ext_c   = RW'(prod_c);
        acc_sub_c = acc - p_ext_c;
    end

    // A subtract step always completes, even without a preceding start
    assign complete_c = !bus.resultRes && (bus.ans_sel == OP_SUB);
    assign xfer_c     = bus.result_valid && bus.out_ready;

    // Accumulator next value; start clears it and overrides ans_sel
    always_comb begin
        acc_nxt_c = acc;
        if (bus.resultRes) begin
            acc_nxt_c = '0;
        end else begin
            case (bus.ans_sel)
                OP_HOLD: acc_nxt_c = acc;
                OP_ADD:  acc_nxt_c = acc + p_ext_c;
                OP_SUB:  acc_nxt_c = acc_sub_c;
                OP_LOAD: acc_nxt_c = p_ext_c;
                default: acc_nxt_c = acc;
            endcase
        end
    end

    // Operand latches, accumulator and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            bus.busy <= 1'b0;
        end else begin
            acc <= acc_nxt_c;
            if (bus.resultRes) begin
                a_reg    <= bus.x_in;
                b_reg    <= bus.y_in;
                bus.busy <= 1'b1;
            end else if (complete_c) begin
                bus.busy <= 1'b0;
            end
        end
    end

    // Output register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            if (complete_c) begin
                bus.result       <= acc_sub_c;
                bus.result_valid <= 1'b1;
                if (bus.result_valid && !bus.out_ready) begin
                    bus.overrun <= 1'b1;
                end
            end else if (xfer_c) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule
